// File: rtl/ofc_filter_engine.sv
// Optimal-filter amplitude engine: pedestal-subtracted weighted sum of NSAMP samples.
// Optional macro OFC_TIMING_EN adds b-coefficient bank, PhaseProduct and phase_overflow.
module ofc_filter_engine #(
  parameter int DATA_W    = 14,
  parameter int NSAMP     = 5,
  parameter int COEF_W    = 32,
  parameter int FRAC_BITS = 20,
  parameter int OUT_W     = 16,
  parameter int ACC_W     = 52
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      triggerIn,
  input  logic [DATA_W-1:0]         signal,
  input  logic                      coef_wr_en,
  input  logic [$clog2(NSAMP):0]    coef_wr_addr,
  input  logic [COEF_W-1:0]         coef_wr_data,
  output logic                      coef_wr_err,
  output logic                      busy,
  output logic [OUT_W-1:0]          PulseHeight,
  output logic                      outValid,
  output logic                      overflow,
`ifdef OFC_TIMING_EN
  output logic [OUT_W-1:0]          PhaseProduct,
  output logic                      phase_overflow,
`endif
  output logic                      trig_dropped
);

  localparam int KW = $clog2(NSAMP);
  localparam int PW = DATA_W + 1 + COEF_W;
  localparam logic [KW-1:0] KLAST = KW'(NSAMP - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0]        ped_q;
  logic [KW-1:0]            k_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [COEF_W-1:0] coef_q [NSAMP];

  logic start, step, finish, wr_ok, wr_err, drop;
  logic [KW-1:0] wr_idx;
  logic wr_bank, idx_ok, bank_ok;

  logic signed [DATA_W:0] diff;
  logic signed [PW-1:0]   prod;
  logic [OUT_W:0]         sat_a;

  assign wr_idx  = coef_wr_addr[KW-1:0];
  assign wr_bank = coef_wr_addr[KW];
  assign idx_ok  = (wr_idx != '0) &&
                   ({1'b0, wr_idx} < (KW+1)'(NSAMP));
`ifdef OFC_TIMING_EN
  assign bank_ok = 1'b1;
`else
  assign bank_ok = !wr_bank;
`endif

  assign diff = $signed({1'b0, signal}) - $signed({1'b0, ped_q});
  assign prod = PW'(diff) * PW'(coef_q[k_q]);

  // Floor-shift out the fraction, then clip; returns {clipped, value}
  function automatic logic [OUT_W:0] sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] r;
    logic [ACC_W-OUT_W:0]    up;
    r  = a >>> FRAC_BITS;
    up = r[ACC_W-1:OUT_W-1];
    if (&up || ~|up)
      return {1'b0, r[OUT_W-1:0]};
    else if (r[ACC_W-1])
      return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  assign sat_a = sat(acc_q);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, phase strobes and write arbitration
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    drop    = 1'b0;
    wr_ok   = 1'b0;
    wr_err  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (triggerIn) begin
          start   = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        step = 1'b1;
        drop = triggerIn;
        if (k_q == KLAST) state_d = DONE;
      end
      DONE: begin
        finish = 1'b1;
        if (triggerIn) begin
          start   = 1'b1;
          state_d = ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (coef_wr_en) begin
      if (state_q != ACCUM && !start && idx_ok && bank_ok)
        wr_ok = 1'b1;
      else
        wr_err = 1'b1;
    end
  end

  // Datapath: pedestal, accumulator, coefficient bank, registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ped_q        <= '0;
      k_q          <= '0;
      acc_q        <= '0;
      busy         <= 1'b0;
      PulseHeight  <= '0;
      overflow     <= 1'b0;
      outValid     <= 1'b0;
      trig_dropped <= 1'b0;
      coef_wr_err  <= 1'b0;
      for (int i = 0; i < NSAMP; i++) coef_q[i] <= '0;
    end else begin
      outValid     <= finish;
      trig_dropped <= drop;
      coef_wr_err  <= wr_err;
      if (start) begin
        ped_q <= signal;
        acc_q <= '0;
        k_q   <= KW'(1);
        busy  <= 1'b1;
      end else if (finish) begin
        busy  <= 1'b0;
      end
      if (step) begin
        acc_q <= acc_q + ACC_W'(prod);
        k_q   <= k_q + KW'(1);
      end
      if (finish) begin
        PulseHeight <= sat_a[OUT_W-1:0];
        overflow    <= sat_a[OUT_W];
      end
      if (wr_ok && !wr_bank) coef_q[wr_idx] <= coef_wr_data;
    end
  end

`ifdef OFC_TIMING_EN
  logic signed [ACC_W-1:0]  acc_b_q;
  logic signed [COEF_W-1:0] coef_b_q [NSAMP];
  logic signed [PW-1:0]     prod_b;
  logic [OUT_W:0]           sat_b;

  assign prod_b = PW'(diff) * PW'(coef_b_q[k_q]);
  assign sat_b  = sat(acc_b_q);

  // Timing accumulator on the b-coefficient bank
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_b_q        <= '0;
      PhaseProduct   <= '0;
      phase_overflow <= 1'b0;
      for (int i = 0; i < NSAMP; i++) coef_b_q[i] <= '0;
    end else begin
      if (start) acc_b_q <= '0;
      if (step)  acc_b_q <= acc_b_q + ACC_W'(prod_b);
      if (finish) begin
        PhaseProduct   <= sat_b[OUT_W-1:0];
        phase_overflow <= sat_b[OUT_W];
      end
      if (wr_ok && wr_bank) coef_b_q[wr_idx] <= coef_wr_data;
    end
  end
`endif

endmodule

// File: tb/tb_ofc_filter_engine.sv
// Directed bench for ofc_filter_engine.
// Table of events plus re-trigger, write-reject and reset sequences.
module tb_ofc_filter_engine;
  localparam int DATA_W = 14;
  localparam int COEF_W = 32;
  localparam int OUT_W  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              triggerIn;
  logic [DATA_W-1:0] signal;
  logic              coef_wr_en;
  logic [3:0]        coef_wr_addr;
  logic [COEF_W-1:0] coef_wr_data;
  logic              coef_wr_err;
  logic              busy;
  logic [OUT_W-1:0]  PulseHeight;
  logic              outValid;
  logic              overflow;
  logic              trig_dropped;
`ifdef OFC_TIMING_EN
  logic [OUT_W-1:0]  PhaseProduct;
  logic              phase_overflow;
`endif

  ofc_filter_engine dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .triggerIn    (triggerIn),
    .signal       (signal),
    .coef_wr_en   (coef_wr_en),
    .coef_wr_addr (coef_wr_addr),
    .coef_wr_data (coef_wr_data),
    .coef_wr_err  (coef_wr_err),
    .busy         (busy),
    .PulseHeight  (PulseHeight),
    .outValid     (outValid),
    .overflow     (overflow),
`ifdef OFC_TIMING_EN
    .PhaseProduct   (PhaseProduct),
    .phase_overflow (phase_overflow),
`endif
    .trig_dropped (trig_dropped)
  );

  typedef struct {
    string             nm;
    logic [DATA_W-1:0] s [5];
    logic [COEF_W-1:0] c [4];
    int                ph;
    logic              ovf;
  } vec_t;

  vec_t tbl [9];
  int n_run  = 0;
  int n_fail = 0;

  function automatic vec_t mk(input string nm,
                              input int s0, input int s1, input int s2,
                              input int s3, input int s4,
                              input int c1, input int c2, input int c3,
                              input int c4, input int ph, input bit ovf);
    vec_t v;
    v.nm   = nm;
    v.s[0] = DATA_W'(s0);
    v.s[1] = DATA_W'(s1);
    v.s[2] = DATA_W'(s2);
    v.s[3] = DATA_W'(s3);
    v.s[4] = DATA_W'(s4);
    v.c[0] = c1;
    v.c[1] = c2;
    v.c[2] = c3;
    v.c[3] = c4;
    v.ph   = ph;
    v.ovf  = ovf;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [COEF_W-1:0] d);
    coef_wr_en   = 1'b1;
    coef_wr_addr = a;
    coef_wr_data = d;
    tick;
    coef_wr_en   = 1'b0;
  endtask

  task automatic load(input vec_t v);
    for (int j = 1; j <= 4; j++) wr(4'(j), v.c[j-1]);
  endtask

  // Trigger with sample 0, then samples 1..4; returns after edge T+4
  task automatic fire(input vec_t v);
    triggerIn = 1'b1;
    signal    = v.s[0];
    tick;
    triggerIn = 1'b0;
    for (int j = 1; j < 5; j++) begin
      signal = v.s[j];
      tick;
    end
  endtask

  initial begin
    bit seen;
    rst_n        = 1'b0;
    triggerIn    = 1'b0;
    signal       = '0;
    coef_wr_en   = 1'b0;
    coef_wr_addr = '0;
    coef_wr_data = '0;

    tbl[0] = mk("pos",       100, 110, 120, 105, 100,
                1<<20, 2<<20, -(1<<20), 0, 45, 0);
    tbl[1] = mk("neg",       200, 190, 180, 200, 200,
                1<<20, 2<<20, -(1<<20), 0, -50, 0);
    tbl[2] = mk("sat_hi",    0, 8000, 0, 0, 0,
                1<<30, 0, 0, 0, 32767, 1);
    tbl[3] = mk("sat_lo",    8000, 0, 8000, 8000, 8000,
                1<<30, 0, 0, 0, -32768, 1);
    tbl[4] = mk("max_exact", 0, 8191, 1, 0, 0,
                4<<20, 3<<20, 0, 0, 32767, 0);
    tbl[5] = mk("max_plus1", 0, 8191, 1, 0, 0,
                4<<20, 4<<20, 0, 0, 32767, 1);
    tbl[6] = mk("floor_pos", 10, 13, 10, 10, 10,
                1<<19, 0, 0, 0, 1, 0);
    tbl[7] = mk("floor_neg", 10, 7, 10, 10, 10,
                1<<19, 0, 0, 0, -2, 0);
    tbl[8] = mk("min_exact", 8192, 0, 8192, 8192, 8192,
                4<<20, 0, 0, 0, -32768, 0);

    tick;
    tick;
    chk("rst_ph",    $signed(PulseHeight), 0);
    chk("rst_valid", outValid, 0);
    chk("rst_ovf",   overflow, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_err",   coef_wr_err, 0);
    chk("rst_drop",  trig_dropped, 0);
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 9; i++) begin
      load(tbl[i]);
      fire(tbl[i]);
      chk({tbl[i].nm, "_early"}, outValid, 0);
      tick;
      chk({tbl[i].nm, "_valid"}, outValid, 1);
      chk({tbl[i].nm, "_ph"},    $signed(PulseHeight), tbl[i].ph);
      chk({tbl[i].nm, "_ovf"},   overflow, tbl[i].ovf);
      chk({tbl[i].nm, "_idle"},  busy, 0);
      tick;
      chk({tbl[i].nm, "_vlow"},  outValid, 0);
      chk({tbl[i].nm, "_hold"},  $signed(PulseHeight), tbl[i].ph);
      chk({tbl[i].nm, "_ohold"}, overflow, tbl[i].ovf);
    end

    // Re-trigger while accumulating, then back-to-back in DONE
    load(tbl[0]);
    triggerIn = 1'b1; signal = 100; tick;
    chk("rt_busy", busy, 1);
    triggerIn = 1'b0; signal = 110; tick;
    triggerIn = 1'b1; signal = 120; tick;
    chk("rt_drop", trig_dropped, 1);
    triggerIn = 1'b0; signal = 105; tick;
    chk("rt_drop_end", trig_dropped, 0);
    signal = 100; tick;
    chk("rt_early", outValid, 0);
    triggerIn = 1'b1; signal = 200; tick;
    chk("b2b_valid", outValid, 1);
    chk("b2b_ph1",   $signed(PulseHeight), 45);
    chk("b2b_drop",  trig_dropped, 0);
    chk("b2b_busy",  busy, 1);
    triggerIn = 1'b0;
    signal = 190; tick;
    signal = 180; tick;
    signal = 200; tick;
    signal = 200; tick;
    chk("b2b_early", outValid, 0);
    tick;
    chk("b2b_valid2", outValid, 1);
    chk("b2b_ph2",    $signed(PulseHeight), -50);

    // Writes rejected at trigger, while busy, and on bad addresses
    coef_wr_en = 1'b1; coef_wr_addr = 4'd1; coef_wr_data = 5 << 20;
    triggerIn = 1'b1; signal = 100; tick;
    chk("wr_trig_err", coef_wr_err, 1);
    triggerIn = 1'b0; signal = 110; tick;
    chk("wr_busy_err", coef_wr_err, 1);
    coef_wr_en = 1'b0;
    signal = 120; tick;
    chk("wr_err_end", coef_wr_err, 0);
    signal = 105; tick;
    signal = 100; tick;
    tick;
    chk("wr_old_coef", $signed(PulseHeight), 45);
    wr(4'd0, 32'd7);
    chk("wr_addr0", coef_wr_err, 1);
    wr(4'd5, 32'd7);
    chk("wr_addr5", coef_wr_err, 1);
`ifndef OFC_TIMING_EN
    wr(4'b1001, 32'd7);
    chk("wr_bank1", coef_wr_err, 1);
`endif
    wr(4'd1, 1 << 20);
    chk("wr_ok", coef_wr_err, 0);
    fire(tbl[0]);
    tick;
    chk("wr_after_bad", $signed(PulseHeight), 45);

    // Reset mid-capture: abort, clear coefficients
    triggerIn = 1'b1; signal = 100; tick;
    triggerIn = 1'b0; signal = 110; tick;
    signal = 120; tick;
    rst_n = 1'b0; signal = 105; tick;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (outValid) seen = 1'b1;
      tick;
    end
    chk("rstm_novalid", seen, 0);
    chk("rstm_ph",      $signed(PulseHeight), 0);
    chk("rstm_busy",    busy, 0);
    fire(tbl[0]);
    tick;
    chk("rstm_valid", outValid, 1);
    chk("rstm_zero",  $signed(PulseHeight), 0);
    chk("rstm_ovf",   overflow, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
